// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator sequencer: opcode constants, opcode class
// decode and the sequencer state encoding.
package calc_sequencer_pkg;

    localparam int CALC_WIDTH = 4;
    localparam int OP_W       = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD_AB = 3'b000;
    localparam op_t OP_SUB_AB = 3'b001;
    localparam op_t OP_ABS_B  = 3'b010;
    localparam op_t OP_ADD_BA = 3'b100;
    localparam op_t OP_SUB_BA = 3'b101;
    localparam op_t OP_ABS_A  = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Single-operand opcodes working on A (11x) or on B (01x).
    function automatic logic is_unary_a(input op_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_unary_b(input op_t op);
        return ~op[2] & op[1];
    endfunction

    function automatic logic is_binary(input op_t op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/calc_sequencer.sv
// Sequential front-end for the combinational calculator: gathers operands over a
// valid/ready input, drives stable A/B/OP, captures R/ovf and offers the result.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH,
    parameter int OPW   = OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [OPW-1:0]   in_op,
    input  logic             chain_en,
    input  logic             clear,
    output logic [WIDTH-1:0] calc_a,
    output logic [WIDTH-1:0] calc_b,
    output logic [OPW-1:0]   calc_op,
    input  logic [WIDTH-1:0] calc_r,
    input  logic             calc_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             sticky_ovf,
    output logic             busy
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] calc_a_q, calc_a_d;
    logic [WIDTH-1:0] calc_b_q, calc_b_d;
    logic [OPW-1:0]   calc_op_q, calc_op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             have_acc_q, have_acc_d;
    logic             out_valid_q, out_valid_d;

    logic chained;
    logic accept_first;
    logic accept_second;

    // A chained operation always issues straight away: A comes from the accumulator.
    assign chained       = chain_en & have_acc_q;
    assign accept_first  = (state_q == IDLE) & in_valid & ~clear;
    assign accept_second = (state_q == WAIT_B) & in_valid & ~clear;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, and reset is
    // sampled on the clock edge here (synchronous), not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (chained || !is_binary(in_op)) begin
                            state_d = ISSUE;
                        end else begin
                            state_d = WAIT_B;
                        end
                    end
                end
                WAIT_B: begin
                    if (in_valid) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == WAIT_B);
        busy     = (state_q != IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        calc_a_d    = calc_a_q;
        calc_b_d    = calc_b_q;
        calc_op_d   = calc_op_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        sticky_d    = sticky_q;
        acc_d       = acc_q;
        have_acc_d  = have_acc_q;
        out_valid_d = out_valid_q;

        if (accept_first) begin
            calc_op_d = in_op;
            if (chained) begin
                calc_a_d = acc_q;
                if (!is_unary_a(in_op)) begin
                    calc_b_d = in_data;
                end
            end else if (is_unary_b(in_op)) begin
                calc_a_d = '0;
                calc_b_d = in_data;
            end else if (is_unary_a(in_op)) begin
                calc_a_d = in_data;
                calc_b_d = '0;
            end else begin
                calc_a_d = in_data;
            end
        end

        if (accept_second) begin
            calc_b_d = in_data;
        end

        if (!clear && state_q == ISSUE) begin
            result_d    = calc_r;
            ovf_d       = calc_ovf;
            sticky_d    = sticky_q | calc_ovf;
            acc_d       = calc_r;
            have_acc_d  = 1'b1;
            out_valid_d = 1'b1;
        end

        if (!clear && state_q == DONE && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Abort drops the pending result and accumulator but keeps the last
        // captured result and the calculator operands visible.
        if (clear) begin
            out_valid_d = 1'b0;
            have_acc_d  = 1'b0;
            sticky_d    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            calc_a_q    <= '0;
            calc_b_q    <= '0;
            calc_op_q   <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            acc_q       <= '0;
            have_acc_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            calc_a_q    <= calc_a_d;
            calc_b_q    <= calc_b_d;
            calc_op_q   <= calc_op_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
            acc_q       <= acc_d;
            have_acc_q  <= have_acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign calc_a     = calc_a_q;
    assign calc_b     = calc_b_q;
    assign calc_op    = calc_op_q;
    assign result     = result_q;
    assign ovf        = ovf_q;
    assign sticky_ovf = sticky_q;
    assign out_valid  = out_valid_q;

endmodule
